// File: rtl/microwave_timer.sv
// Countdown timer for a microwave oven: keypad sets the time, a prescaled tick counts it down
// while the oven heats, and one-cycle start/finish pulses go to the oven FSM.
module microwave_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int STEP_SEC = 30,
  parameter int MAX_SEC  = 990
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       door,
  input  logic       key_add,
  input  logic       key_start,
  input  logic       key_cancel,
  input  logic       heat,
  output logic       start,
  output logic       finish,
  output logic [9:0] remaining,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [10:0]   STEP11   = 11'(STEP_SEC);
  localparam logic [10:0]   MAX11    = 11'(MAX_SEC);

  state_t        state, state_next;
  logic [PW-1:0] prescale, prescale_next;
  logic [9:0]    remaining_next;
  logic          start_next, finish_next;
  logic          tick;
  logic [10:0]   add_sum;
  logic [9:0]    add_sat;

  assign busy = (state != IDLE);
  assign tick = (state == RUN) && heat && (prescale == PRE_LAST);

  // A key_add coinciding with a second tick folds the decrement into the sum.
  always_comb begin
    add_sum = {1'b0, remaining} + STEP11 - (tick ? 11'd1 : 11'd0);
    add_sat = (add_sum > MAX11) ? MAX11[9:0] : add_sum[9:0];
  end

  always_comb begin
    state_next     = state;
    prescale_next  = prescale;
    remaining_next = remaining;
    start_next     = 1'b0;
    finish_next    = 1'b0;
    case (state)
      IDLE: begin
        prescale_next = '0;
        if (key_cancel) begin
          remaining_next = '0;
        end else if (key_start) begin
          if (!door) begin
            if (remaining == '0) remaining_next = STEP11[9:0];
            state_next = RUN;
            start_next = 1'b1;
          end
        end else if (key_add) begin
          remaining_next = add_sat;
        end
      end
      RUN: begin
        if (heat) prescale_next = tick ? '0 : prescale + PW'(1);
        if (key_cancel) begin
          remaining_next = '0;
          prescale_next  = '0;
          state_next     = DONE;
          finish_next    = 1'b1;
        end else if (key_add && !key_start) begin
          remaining_next = add_sat;
        end else if (tick) begin
          if (remaining > 10'd1) begin
            remaining_next = remaining - 10'd1;
          end else begin
            remaining_next = '0;
            state_next     = DONE;
            finish_next    = 1'b1;
          end
        end
      end
      DONE: begin
        prescale_next = '0;
        state_next    = IDLE;
      end
      default: begin
        state_next    = IDLE;
        prescale_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      prescale  <= '0;
      remaining <= '0;
      start     <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state     <= state_next;
      prescale  <= prescale_next;
      remaining <= remaining_next;
      start     <= start_next;
      finish    <= finish_next;
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV=4, STEP_SEC=30, MAX_SEC=990.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       door = 1'b0;
  logic       key_add = 1'b0;
  logic       key_start = 1'b0;
  logic       key_cancel = 1'b0;
  logic       heat = 1'b0;
  logic       start;
  logic       finish;
  logic [9:0] remaining;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cnt;

  microwave_timer #(.TICK_DIV(4), .STEP_SEC(30), .MAX_SEC(990)) dut (
    .clk(clk), .nrst(nrst), .door(door), .key_add(key_add), .key_start(key_start),
    .key_cancel(key_cancel), .heat(heat), .start(start), .finish(finish),
    .remaining(remaining), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_finish"}, 32'(finish), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Asynchronous reset between clock edges
    #2 nrst = 1'b0;
    #1 outs_zero("rst_async");
    step();
    nrst = 1'b1;
    step();
    outs_zero("rst_release");

    // Two adds, start, count down 60 s of 4 heat cycles each
    key_add = 1'b1; step(); step(); key_add = 1'b0;
    check("add2_rem", 32'(remaining), 32'd60);
    key_start = 1'b1; step(); key_start = 1'b0;
    check("run_start", 32'(start), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    heat = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      cnt++;
      if (cnt == 1) check("run_start_once", 32'(start), 32'd0);
      if (cnt == 4) check("run_first_sec", 32'(remaining), 32'd59);
      if (finish) break;
    end
    check("run_heat_cycles", 32'(cnt), 32'd240);
    check("run_finish_rem", 32'(remaining), 32'd0);
    check("run_done_busy", 32'(busy), 32'd1);
    heat = 1'b0;
    step();
    check("run_finish_once", 32'(finish), 32'd0);
    check("run_idle_busy", 32'(busy), 32'd0);

    // key_start from empty loads STEP_SEC; with door open it is ignored
    key_start = 1'b1; step(); key_start = 1'b0;
    check("empty_start_rem", 32'(remaining), 32'd30);
    check("empty_start_pulse", 32'(start), 32'd1);
    key_cancel = 1'b1; step(); key_cancel = 1'b0;
    step();
    door = 1'b1;
    key_start = 1'b1; step(); key_start = 1'b0;
    check("door_start_pulse", 32'(start), 32'd0);
    check("door_start_rem", 32'(remaining), 32'd0);
    check("door_start_busy", 32'(busy), 32'd0);
    door = 1'b0;

    // Heat pause after two prescaler counts
    key_add = 1'b1; step(); key_add = 1'b0;
    key_start = 1'b1; step(); key_start = 1'b0;
    heat = 1'b1; step(); step();
    heat = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pause_rem", 32'(remaining), 32'd30);
    check("pause_busy", 32'(busy), 32'd1);
    heat = 1'b1;
    cnt = 2;
    for (int i = 0; i < 300; i++) begin
      step();
      cnt++;
      if (cnt == 4) check("pause_resume_sec", 32'(remaining), 32'd29);
      if (finish) break;
    end
    check("pause_heat_cycles", 32'(cnt), 32'd120);
    heat = 1'b0;
    step();

    // Saturation, cancel in IDLE
    key_add = 1'b1;
    for (int i = 0; i < 34; i++) step();
    key_add = 1'b0;
    check("sat_rem", 32'(remaining), 32'd990);
    key_cancel = 1'b1; step(); key_cancel = 1'b0;
    check("idle_cancel_rem", 32'(remaining), 32'd0);
    check("idle_cancel_finish", 32'(finish), 32'd0);

    // key_add coinciding with a tick at remaining=5
    key_add = 1'b1; step(); key_add = 1'b0;
    key_start = 1'b1; step(); key_start = 1'b0;
    heat = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cnt++;
      if (remaining == 10'd5) break;
    end
    check("to5_cycles", 32'(cnt), 32'd100);
    step(); step(); step();
    check("pre_tick_rem", 32'(remaining), 32'd5);
    key_add = 1'b1; step(); key_add = 1'b0;
    check("add_tick_rem", 32'(remaining), 32'd34);
    check("add_tick_finish", 32'(finish), 32'd0);

    // Cancel in RUN at remaining=17
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cnt++;
      if (remaining == 10'd17) break;
    end
    check("to17_cycles", 32'(cnt), 32'd68);
    key_cancel = 1'b1; step(); key_cancel = 1'b0;
    check("run_cancel_rem", 32'(remaining), 32'd0);
    check("run_cancel_finish", 32'(finish), 32'd1);
    step();
    check("run_cancel_once", 32'(finish), 32'd0);
    check("run_cancel_idle", 32'(busy), 32'd0);
    heat = 1'b0;

    // Cancel beats start in IDLE
    key_add = 1'b1; step(); key_add = 1'b0;
    key_cancel = 1'b1; key_start = 1'b1; step(); key_cancel = 1'b0; key_start = 1'b0;
    check("cancel_start_rem", 32'(remaining), 32'd0);
    check("cancel_start_pulse", 32'(start), 32'd0);
    check("cancel_start_busy", 32'(busy), 32'd0);

    // Reset mid-RUN abandons the cycle
    key_add = 1'b1; step(); key_add = 1'b0;
    key_start = 1'b1; step(); key_start = 1'b0;
    heat = 1'b1; step(); step(); step();
    #2 nrst = 1'b0;
    #1 outs_zero("rst_run");
    step();
    nrst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (finish || busy || start) cnt++;
    end
    check("rst_run_quiet", 32'(cnt), 32'd0);
    check("rst_run_rem", 32'(remaining), 32'd0);
    heat = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
